// File: rtl/cpu_package.sv
// Shared RV32I decode types: opcode/type/ALU encodings, decoded bundle, immediate helpers.
// Pure declarations; no timing.
// No flow control.
package cpu_package;

  localparam int CPU_XLEN = 32;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [6:0] {
    LOAD     = 7'b0000011,
    MISC_MEM = 7'b0001111,
    OP_IMM   = 7'b0010011,
    AUIPC    = 7'b0010111,
    STORE    = 7'b0100011,
    OP       = 7'b0110011,
    LUI      = 7'b0110111,
    BRANCH   = 7'b1100011,
    JALR     = 7'b1100111,
    JAL      = 7'b1101111,
    SYSTEM   = 7'b1110011
  } opcode_type_t;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } instruction_type_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_function_t;

  typedef struct packed {
    logic [CPU_XLEN-1:0] pc;
    opcode_type_t        opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [CPU_XLEN-1:0] imm;
    instruction_type_t   itype;
    alu_function_t       alu_fn;
    logic                illegal;
  } decoded_instr_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // R-type (and anything unexpected) carries no immediate.
  function automatic logic [31:0] extract_imm(input logic [31:0] instr,
                                              input instruction_type_t itype);
    case (itype)
      I_TYPE:  return imm_i(instr);
      S_TYPE:  return imm_s(instr);
      B_TYPE:  return imm_b(instr);
      U_TYPE:  return imm_u(instr);
      J_TYPE:  return imm_j(instr);
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Wires only; no latency.
// valid/ready on both sides; master drives fetch inputs and out_ready.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic [2:0]      out_alu_fn;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_type, out_alu_fn, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_type, out_alu_fn, out_illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: instruction word + PC -> decoded bundle.
// Zero latency.
// No flow control; the enclosing stage registers the result.
module instr_decoder
  import cpu_package::*;
#(
  parameter bit ALLOW_SYSTEM = 1'b1
) (
  input  logic [31:0]    instr,
  input  logic [31:0]    pc,
  output decoded_instr_t dec
);

  instruction_type_t itype;
  alu_function_t     alu_fn;
  logic              legal;
  logic [2:0]        funct3;
  logic [6:0]        funct7;

  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Classify the opcode into a format, ALU operation and legality.
  always_comb begin
    itype  = R_TYPE;
    alu_fn = ALU_ADD;
    legal  = 1'b1;
    case (instr[6:0])
      OP: begin
        itype = R_TYPE;
        case (funct3)
          3'b000: begin
            if (funct7 == FUNCT7_BASE)     alu_fn = ALU_ADD;
            else if (funct7 == FUNCT7_ALT) alu_fn = ALU_SUB;
            else                           legal  = 1'b0;
          end
          3'b111: begin
            if (funct7 == FUNCT7_BASE) alu_fn = ALU_AND;
            else                       legal  = 1'b0;
          end
          3'b110: begin
            if (funct7 == FUNCT7_BASE) alu_fn = ALU_OR;
            else                       legal  = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        itype = I_TYPE;
        case (funct3)
          3'b000:  alu_fn = ALU_ADD;
          3'b111:  alu_fn = ALU_AND;
          3'b110:  alu_fn = ALU_OR;
          default: legal  = 1'b0;
        endcase
      end
      LOAD, JALR:       itype = I_TYPE;
      SYSTEM, MISC_MEM: begin
        itype = I_TYPE;
        legal = ALLOW_SYSTEM;
      end
      STORE:            itype = S_TYPE;
      BRANCH: begin
        itype  = B_TYPE;
        alu_fn = ALU_SUB;
      end
      LUI, AUIPC:       itype = U_TYPE;
      JAL:              itype = J_TYPE;
      default:          legal = 1'b0;
    endcase
    // Compressed encodings are not supported.
    if (instr[1:0] != 2'b11) legal = 1'b0;
  end

  // Assemble the bundle; illegal words collapse to a harmless R-type ADD with no immediate.
  always_comb begin
    dec        = '0;
    dec.pc     = pc;
    dec.opcode = opcode_type_t'(instr[6:0]);
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.funct3 = funct3;
    dec.funct7 = funct7;
    if (legal) begin
      dec.itype   = itype;
      dec.alu_fn  = alu_fn;
      dec.imm     = extract_imm(instr, itype);
      dec.illegal = 1'b0;
    end else begin
      dec.itype   = R_TYPE;
      dec.alu_fn  = ALU_ADD;
      dec.imm     = 32'd0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: fetch handshake -> registered decoded bundle.
// One cycle: accepted at edge N, valid after edge N.
// Main + skid register; in_ready depends only on skid state and reset, never on out_ready.
module decode_stage
  import cpu_package::*;
#(
  parameter int XLEN         = 32,
  parameter bit ALLOW_SYSTEM = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage supports XLEN=32 only");
  end

  decoded_instr_t dec;
  decoded_instr_t main_dat;
  decoded_instr_t skid_dat;
  logic           main_vld;
  logic           skid_vld;
  logic           accept;
  logic           main_free;

  instr_decoder #(.ALLOW_SYSTEM(ALLOW_SYSTEM)) u_instr_decoder (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .dec   (dec)
  );

  assign bus.in_ready = !skid_vld && !reset;
  assign accept       = bus.in_valid && bus.in_ready;
  // Main can take a new entry when empty or when its current one leaves this edge.
  assign main_free    = !main_vld || bus.out_ready;

  // Main/skid register pair: flush wins, skid refills main first, stalled accepts park in skid.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (main_free) begin
      if (skid_vld) begin
        main_dat <= skid_dat;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_dat <= dec;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_dat <= dec;
      skid_vld <= 1'b1;
    end
  end

  assign bus.out_valid   = main_vld;
  assign bus.out_pc      = main_dat.pc;
  assign bus.out_opcode  = main_dat.opcode;
  assign bus.out_rd      = main_dat.rd;
  assign bus.out_rs1     = main_dat.rs1;
  assign bus.out_rs2     = main_dat.rs2;
  assign bus.out_funct3  = main_dat.funct3;
  assign bus.out_funct7  = main_dat.funct7;
  assign bus.out_imm     = main_dat.imm;
  assign bus.out_type    = main_dat.itype;
  assign bus.out_alu_fn  = main_dat.alu_fn;
  assign bus.out_illegal = main_dat.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases then random traffic against a 2-deep queue model.
// Two instances (system opcodes allowed / disallowed) share the same stimulus.
// Random out_ready, flush and reset exercise stall, skid and discard paths.
module tb_decode_stage;
  import cpu_package::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic rst_drv;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] q[$];   // {pc, instr} of entries held by the stage, oldest first

  decode_stage_if #(.XLEN(32)) if_a ();
  decode_stage_if #(.XLEN(32)) if_b ();

  decode_stage #(.XLEN(32), .ALLOW_SYSTEM(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(if_a.slave));
  decode_stage #(.XLEN(32), .ALLOW_SYSTEM(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .bus(if_b.slave));

  assign if_b.in_valid  = if_a.in_valid;
  assign if_b.in_instr  = if_a.in_instr;
  assign if_b.in_pc     = if_a.in_pc;
  assign if_b.out_ready = if_a.out_ready;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ISA-level reference decode, written from the instruction-set tables.
  function automatic decoded_instr_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                                input bit allow_sys);
    decoded_instr_t d;
    int  simm;
    bit  ok;
    int  f3;
    int  f7;
    d = '0;
    d.pc = pc;
    d.opcode = opcode_type_t'(ins[6:0]);
    d.rd = ins[11:7];
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.funct3 = ins[14:12];
    d.funct7 = ins[31:25];
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    ok = 1'b1;
    d.alu_fn = ALU_ADD;
    d.itype = R_TYPE;
    case (ins[6:0])
      7'h33: begin
        if (f3 == 0 && f7 == 0)         d.alu_fn = ALU_ADD;
        else if (f3 == 0 && f7 == 32)   d.alu_fn = ALU_SUB;
        else if (f3 == 7 && f7 == 0)    d.alu_fn = ALU_AND;
        else if (f3 == 6 && f7 == 0)    d.alu_fn = ALU_OR;
        else ok = 1'b0;
      end
      7'h13: begin
        d.itype = I_TYPE;
        if (f3 == 7)      d.alu_fn = ALU_AND;
        else if (f3 == 6) d.alu_fn = ALU_OR;
        else if (f3 != 0) ok = 1'b0;
      end
      7'h03, 7'h67: d.itype = I_TYPE;
      7'h73, 7'h0F: begin d.itype = I_TYPE; ok = allow_sys; end
      7'h23: d.itype = S_TYPE;
      7'h63: begin d.itype = B_TYPE; d.alu_fn = ALU_SUB; end
      7'h37, 7'h17: d.itype = U_TYPE;
      7'h6F: d.itype = J_TYPE;
      default: ok = 1'b0;
    endcase
    simm = 0;
    case (d.itype)
      I_TYPE: simm = $signed(ins) >>> 20;
      S_TYPE: simm = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
      B_TYPE: simm = (($signed(ins) >>> 31) * 4096) + int'(ins[7]) * 2048
                     + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      U_TYPE: simm = int'(ins & 32'hFFFF_F000);
      J_TYPE: simm = (($signed(ins) >>> 31) * 1048576) + int'(ins[19:12]) * 4096
                     + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: simm = 0;
    endcase
    d.imm = simm;
    if (!ok) begin
      d.itype = R_TYPE;
      d.alu_fn = ALU_ADD;
      d.imm = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  task automatic compare_side(input string side, input logic vld, input logic rdy,
                              input logic [31:0] pc, input logic [6:0] opc,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                              input logic [2:0] typ, input logic [2:0] alu, input logic ill,
                              input bit allow_sys);
    decoded_instr_t e;
    check({side, "_in_ready"}, rdy, (!rst_drv && q.size() < 2));
    check({side, "_out_valid"}, vld, (q.size() > 0));
    if (q.size() > 0 && vld) begin
      e = ref_decode(q[0][31:0], q[0][63:32], allow_sys);
      check({side, "_pc"}, pc, e.pc);
      check({side, "_opcode"}, opc, e.opcode);
      check({side, "_rd"}, rd, e.rd);
      check({side, "_rs1"}, rs1, e.rs1);
      check({side, "_rs2"}, rs2, e.rs2);
      check({side, "_funct3"}, f3, e.funct3);
      check({side, "_funct7"}, f7, e.funct7);
      check({side, "_imm"}, imm, e.imm);
      check({side, "_type"}, typ, e.itype);
      check({side, "_alu"}, alu, e.alu_fn);
      check({side, "_illegal"}, ill, e.illegal);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, compare at the next negedge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rst);
    bit acc;
    if_a.in_valid  = iv;
    if_a.in_instr  = ins;
    if_a.in_pc     = pc;
    if_a.out_ready = ordy;
    flush          = fl;
    reset          = rst;
    rst_drv        = rst;
    if (rst || fl) begin
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back({pc, ins});
    end
    @(negedge clk);
    compare_side("a", if_a.out_valid, if_a.in_ready, if_a.out_pc, if_a.out_opcode, if_a.out_rd,
                 if_a.out_rs1, if_a.out_rs2, if_a.out_funct3, if_a.out_funct7, if_a.out_imm,
                 if_a.out_type, if_a.out_alu_fn, if_a.out_illegal, 1'b1);
    compare_side("b", if_b.out_valid, if_b.in_ready, if_b.out_pc, if_b.out_opcode, if_b.out_rd,
                 if_b.out_rs1, if_b.out_rs2, if_b.out_funct3, if_b.out_funct7, if_b.out_imm,
                 if_b.out_type, if_b.out_alu_fn, if_b.out_illegal, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [11];
    int          sel;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 7) begin
      r[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0:       r[31:25] = 7'h00;
        1:       r[31:25] = 7'h20;
        default: ;
      endcase
    end else if (sel == 7) begin
      r[1:0] = 2'($urandom_range(0, 2));
    end
    return r;
  endfunction

  initial begin
    if_a.in_valid = 1'b0; if_a.in_instr = '0; if_a.in_pc = '0; if_a.out_ready = 1'b0;
    flush = 1'b0; reset = 1'b1; rst_drv = 1'b1;

    // Reset state
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("rst_out_valid", if_a.out_valid, 0);
    check("rst_in_ready", if_a.in_ready, 0);
    check("rst_out_pc", if_a.out_pc, 0);
    check("rst_out_imm", if_a.out_imm, 0);
    check("rst_out_rd", if_a.out_rd, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check("post_rst_in_ready", if_a.in_ready, 1);

    // Directed decodes
    cycle(1, 32'hFFF00093, 32'h0, 1, 0, 0);
    check("addi_valid", if_a.out_valid, 1);
    check("addi_opcode", if_a.out_opcode, 7'h13);
    check("addi_type", if_a.out_type, I_TYPE);
    check("addi_rd", if_a.out_rd, 1);
    check("addi_rs1", if_a.out_rs1, 0);
    check("addi_imm", if_a.out_imm, 32'hFFFFFFFF);
    check("addi_alu", if_a.out_alu_fn, ALU_ADD);
    check("addi_illegal", if_a.out_illegal, 0);
    cycle(1, 32'h402081B3, 32'h4, 1, 0, 0);
    check("sub_type", if_a.out_type, R_TYPE);
    check("sub_alu", if_a.out_alu_fn, ALU_SUB);
    check("sub_rd", if_a.out_rd, 3);
    check("sub_rs1", if_a.out_rs1, 1);
    check("sub_rs2", if_a.out_rs2, 2);
    check("sub_funct7", if_a.out_funct7, 7'h20);
    check("sub_imm", if_a.out_imm, 0);
    cycle(1, 32'h123452B7, 32'h8, 1, 0, 0);
    check("lui_type", if_a.out_type, U_TYPE);
    check("lui_imm", if_a.out_imm, 32'h12345000);
    cycle(1, 32'hFE000EE3, 32'h100, 1, 0, 0);
    check("beq_type", if_a.out_type, B_TYPE);
    check("beq_alu", if_a.out_alu_fn, ALU_SUB);
    check("beq_imm", if_a.out_imm, 32'hFFFFFFFC);
    check("beq_pc", if_a.out_pc, 32'h100);
    cycle(0, 0, 0, 1, 0, 0);
    check("drain_valid", if_a.out_valid, 0);

    // Stall: two accepted, third held by fetch, then drained in order
    cycle(1, 32'h00000013, 32'h0, 0, 0, 0);
    cycle(1, 32'h00000013, 32'h4, 0, 0, 0);
    check("stall_in_ready", if_a.in_ready, 0);
    check("stall_pc_a", if_a.out_pc, 32'h0);
    cycle(1, 32'h00000013, 32'h8, 0, 0, 0);
    check("stall_hold_pc", if_a.out_pc, 32'h0);
    check("stall_hold_in_ready", if_a.in_ready, 0);
    cycle(1, 32'h00000013, 32'h8, 1, 0, 0);
    check("emerge_pc_4", if_a.out_pc, 32'h4);
    cycle(1, 32'h00000013, 32'h8, 1, 0, 0);
    check("emerge_pc_8", if_a.out_pc, 32'h8);
    check("emerge_valid_8", if_a.out_valid, 1);
    cycle(0, 0, 0, 1, 0, 0);
    check("emerge_done", if_a.out_valid, 0);

    // Flush with both entries full and an input offered
    cycle(1, 32'h00000013, 32'h10, 0, 0, 0);
    cycle(1, 32'h00000013, 32'h14, 0, 0, 0);
    cycle(1, 32'h00000013, 32'hC, 0, 1, 0);
    check("flush_valid", if_a.out_valid, 0);
    check("flush_in_ready", if_a.in_ready, 1);
    cycle(1, 32'h00000013, 32'h200, 1, 0, 0);
    check("post_flush_pc", if_a.out_pc, 32'h200);
    cycle(0, 0, 0, 1, 0, 0);
    check("post_flush_alone", if_a.out_valid, 0);

    // Illegal encodings
    cycle(1, 32'h00000000, 32'h300, 1, 0, 0);
    check("zero_illegal", if_a.out_illegal, 1);
    check("zero_alu", if_a.out_alu_fn, ALU_ADD);
    check("zero_imm", if_a.out_imm, 0);
    cycle(1, 32'hFFFFFFFF, 32'h304, 1, 0, 0);
    check("ones_illegal", if_a.out_illegal, 1);
    check("ones_imm", if_a.out_imm, 0);
    check("ones_type", if_a.out_type, R_TYPE);
    cycle(1, 32'h00000073, 32'h308, 1, 0, 0);
    check("ecall_sys_off_illegal", if_b.out_illegal, 1);
    check("ecall_sys_on_legal", if_a.out_illegal, 0);
    check("ecall_sys_on_type", if_a.out_type, I_TYPE);
    cycle(0, 0, 0, 1, 0, 0);

    // Reset mid-stall
    cycle(1, 32'h00000013, 32'h400, 0, 0, 0);
    cycle(1, 32'h00000013, 32'h404, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("midrst_valid", if_a.out_valid, 0);
    check("midrst_in_ready", if_a.in_ready, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_instr(), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32I instruction decode stage between instruction fetch and the register-read/ALU stage.
- Accepts one fetched instruction word plus PC per valid/ready handshake.
- Produces a registered decoded bundle: opcode, register indices, funct fields, sign-extended immediate, instruction type, ALU function and illegal flag.
- A two-entry skid buffer keeps in_ready registered-quality so no combinational path runs from out_ready to in_ready.

Parameters:
XLEN, 32, datapath width; only 32 is supported, enforced by elaboration assertion
ALLOW_SYSTEM, 1, when 0 SYSTEM and MISC_MEM opcodes are flagged illegal

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
flush  input  1  discard all buffered instructions (branch redirect)
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept
in_instr  input  32  instruction word
in_pc  input  XLEN  instruction address
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts
out_pc  output  XLEN  PC of decoded instruction
out_opcode  output  7  opcode_type_t value
out_rd / out_rs1 / out_rs2  output  5 each  instr[11:7] / [19:15] / [24:20]
out_funct3  output  3  instr[14:12]
out_funct7  output  7  instr[31:25]
out_imm  output  XLEN  sign-extended immediate
out_type  output  3  instruction_type_t value
out_alu_fn  output  3  alu_function_t value
out_illegal  output  1  undecodable instruction

Behaviour:
- Reset: out_valid=0, skid empty, all out_* data fields 0, in_ready=0 while reset is high; in_ready=1 in the first cycle after reset falls.
- Transfer occurs on a rising edge with valid&&ready high on that side.
- Latency: input accepted at edge N appears with out_valid=1 after edge N, with no bubble if out_ready stays high.
- Order is preserved; no loss, no duplication.
- Storage: main output register plus one skid register. in_ready = !skid_valid && !reset.
- Accept while the main register is stalled (out_valid && !out_ready) writes the skid register.
- When main drains and skid is valid, skid moves to main in the same edge.
- Simultaneous accept and drain with skid empty: new entry goes directly to main.
- Data fields are held stable while out_valid && !out_ready.
- flush has priority over everything. At the edge it is sampled: main and skid are invalidated, and any input accepted that same cycle is dropped. in_ready=1 in the next cycle.
- Decode is combinational on the input side and registered into the skid or main entry.
- Type mapping:
  - OP → R_TYPE
  - LOAD, OP_IMM, JALR, SYSTEM, MISC_MEM → I_TYPE
  - STORE → S_TYPE
  - BRANCH → B_TYPE
  - LUI, AUIPC → U_TYPE
  - JAL → J_TYPE
- Immediates:
  - I: sext(instr[31:20])
  - S: sext({[31:25],[11:7]})
  - B: sext({[31],[7],[30:25],[11:8],0})
  - U: {[31:12],12'b0}
  - J: sext({[31],[19:12],[20],[30:21],0})
  - R: 0
- ALU function:
  - OP funct3 000: funct7 0000000 → ADD, funct7 0100000 → SUB
  - OP/OP_IMM funct3 111 → AND, 110 → OR, OP_IMM 000 → ADD
  - LOAD, STORE, AUIPC, LUI, JAL, JALR → ADD
  - BRANCH → SUB
- Illegal (out_illegal=1, alu ADD, type R_TYPE, imm 0):
  - instr[1:0] != 2'b11
  - unknown opcode
  - OP/OP_IMM funct3/funct7 combination not listed above
  - SYSTEM/MISC_MEM when ALLOW_SYSTEM=0
- Illegal instructions still flow through the handshake normally.

Decomposition:
- Shared package cpu_package gains:
  - decoded_instr_t packed struct (all out_* fields except valid)
  - immediate-extract functions per instruction_type_t
  - funct7 constants FUNCT7_BASE=7'b0000000, FUNCT7_ALT=7'b0100000
- One sub-module: instr_decoder, combinational instr+pc → decoded_instr_t.
- decode_stage instantiates instr_decoder and holds the main/skid register pair and handshake control.

Test Plan:
- Reset then 0xFFF00093 (addi x1,x0,-1) with out_ready=1 → next cycle out_valid=1, OP_IMM, I_TYPE, rd=1, rs1=0, imm=0xFFFFFFFF, ADD, illegal=0.
- 0x402081B3 (sub x3,x1,x2) → R_TYPE, SUB, rd=3, rs1=1, rs2=2, funct7=0x20, imm=0; 0x123452B7 (lui x5) → U_TYPE, imm=0x12345000.
- 0xFE000EE3 (beq x0,x0,-4) at pc=0x100 → B_TYPE, SUB, imm=0xFFFFFFFC, out_pc=0x100.
- out_ready=0, push pc 0x0/0x4/0x8 back-to-back → first two accepted, in_ready=0 after the second, 0x8 held by fetch; raise out_ready → bundles emerge 0x0, 0x4, 0x8 on consecutive cycles, outputs stable while stalled.
- Both entries full, assert flush with in_valid=1 (pc 0xC) → next cycle out_valid=0, in_ready=1, 0xC never emerges; next push pc 0x200 emerges alone.
- 0x00000000 and 0xFFFFFFFF → out_illegal=1, ADD, imm=0; with ALLOW_SYSTEM=0, 0x00000073 → illegal=1; reset asserted mid-stall → out_valid=0 after the edge, in_ready=0 during reset.
